pmem_arbiter: RTL and testbench
===============================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, address/data width.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports ifu_req_valid input 1 / ifu_req_ready output 1 / ifu_addr input XLEN: fetch request handshake and address.
REQ-005 SHALL have ports ifu_resp_valid output 1 / ifu_rdata output XLEN: fetch response.
REQ-006 SHALL have ports lsu_req_valid input 1 / lsu_req_ready output 1 / lsu_wen input 1 / lsu_signed input 1 / lsu_addr input XLEN / lsu_wdata input XLEN / lsu_rmask input XLEN: load/store request.
REQ-007 SHALL have ports lsu_resp_valid output 1 / lsu_rdata output XLEN: load data or store acknowledge.
REQ-008 SHALL have ports pmem_mem_en / pmem_w_en / pmem_signed_en output 1, pmem_addr / pmem_w_data / pmem_r_mask output XLEN, pmem_r_data input XLEN: drive the shared Pmem instance.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction per 3 cycles max.
REQ-011 In IDLE, SHALL assert req_ready only to the single granted requester; both readys low in ACCESS/RESP.
REQ-012 Handshake: transfer occurs when valid && ready in IDLE; SHALL latch owner id and all request fields; next state ACCESS.
REQ-013 Valid deasserted before handshake SHALL carry no commitment; no latching, no grant-pointer update.
REQ-014 IFU request SHALL be latched as w_en=0, signed_en=0, r_mask=all ones, w_data=0.
REQ-015 In ACCESS (exactly one cycle), SHALL drive pmem_mem_en=1 with latched fields; pmem_r_data registered at end of cycle; next state RESP.
REQ-016 Outside ACCESS, pmem_mem_en and pmem_w_en SHALL be 0; other pmem_* outputs SHALL be 0.
REQ-017 In RESP, SHALL assert owner's resp_valid for exactly one cycle with registered data; other resp_valid low; next state IDLE.
REQ-018 Store response: lsu_rdata SHALL be 0 with lsu_resp_valid=1 (acknowledge).
REQ-019 rdata outputs SHALL be 0 whenever their resp_valid is low.
REQ-020 Responses SHALL not be back-pressured; requesters sample in the RESP cycle.
REQ-021 Request-to-response latency: handshake cycle N -> resp_valid in cycle N+2.

Reset
REQ-022 On reset: state=IDLE, owner=IFU, grant pointer=IFU, data register=0, all outputs 0 in following cycle.
REQ-023 Reset in ACCESS or RESP SHALL abort the transaction; no resp_valid issued for it.

Configuration
REQ-024 Macro PMEM_ARB_RR_EN defined: round-robin; on simultaneous valid, grant the requester not granted last; pointer updates on each handshake; reset pointer=IFU so first conflict goes to LSU.
REQ-025 PMEM_ARB_RR_EN undefined: fixed priority, LSU wins every conflict; no pointer register.
REQ-026 With a single valid requester, both modes SHALL grant it immediately.

Structure
REQ-027 Package pmem_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), requester id enum (IFU=0, LSU=1), and XLEN default.
REQ-028 Grant logic SHALL be sub-module pmem_grant (inputs two valids + pointer, output one-hot grant); FSM and registers stay in pmem_arbiter.

Verification
REQ-029 IFU read addr 0x8000_0000, pmem_r_data=0x0000_0013 -> pmem_mem_en high exactly cycle N+1, ifu_resp_valid at N+2 with ifu_rdata=0x13.
REQ-030 LSU store addr 0x8000_0100 wdata 0xDEADBEEF -> pmem_w_en=1 one cycle, lsu_resp_valid N+2 with lsu_rdata=0.
REQ-031 Both valid every cycle, 6 transactions: RR_EN -> grants LSU,IFU,LSU,IFU,LSU,IFU; no RR_EN -> six LSU grants.
REQ-032 Reset asserted in ACCESS cycle -> no resp_valid, busy=0 next cycle, next request accepted normally.
REQ-033 ifu_req_valid pulsed one cycle while busy -> no grant, no pmem access, pointer unchanged.

Source files
------------

// File: rtl/pmem_pkg.sv
// -----------------------------------------------------------------------------
// pmem_pkg
// Shared types for the Pmem arbiter:
//   XLEN_DEFAULT : default address/data width
//   state_e      : arbiter FSM states (IDLE -> ACCESS -> RESP)
//   req_id_e     : requester identifiers (IFU=0, LSU=1)
// -----------------------------------------------------------------------------
package pmem_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        IFU = 1'b0,
        LSU = 1'b1
    } req_id_e;

endpackage

// File: rtl/pmem_grant.sv
// -----------------------------------------------------------------------------
// pmem_grant
// Two-requester grant selection. A lone valid requester always wins; when both
// are valid the requester that was NOT granted last gets the grant.
// Ports:
//   ifu_valid_i : IFU request valid
//   lsu_valid_i : LSU request valid
//   last_i      : requester granted most recently (tie-break pointer)
//   grant_o     : one-hot grant, bit 0 = IFU, bit 1 = LSU (zero when idle)
// -----------------------------------------------------------------------------
module pmem_grant
    import pmem_pkg::*;
(
    input  logic       ifu_valid_i,
    input  logic       lsu_valid_i,
    input  req_id_e    last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (ifu_valid_i && lsu_valid_i) begin
            grant_o = (last_i == IFU) ? 2'b10 : 2'b01;
        end else if (ifu_valid_i) begin
            grant_o = 2'b01;
        end else if (lsu_valid_i) begin
            grant_o = 2'b10;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
// Shares a single Pmem instance between the instruction fetch unit (IFU) and
// the load/store unit (LSU). One transaction at a time:
//   IDLE   : grant one requester, latch its request on valid && ready
//   ACCESS : drive the Pmem for exactly one cycle, register read data
//   RESP   : one-cycle response pulse to the owner (no back-pressure)
// Handshake in cycle N gives resp_valid in cycle N+2.
//
// Configuration macro: PMEM_ARB_RR_EN
//   defined   -> round-robin on conflicts (pointer reset to IFU, so the first
//                conflict goes to the LSU)
//   undefined -> fixed priority, LSU wins every conflict, no pointer register
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   ifu_req_valid/ready     : fetch request handshake, ifu_addr address
//   ifu_resp_valid/rdata    : fetch response
//   lsu_req_valid/ready     : load/store request handshake with lsu_wen,
//                             lsu_signed, lsu_addr, lsu_wdata, lsu_rmask
//   lsu_resp_valid/rdata    : load data or store acknowledge (rdata 0)
//   pmem_*                  : shared Pmem interface, zero outside ACCESS
//   busy                    : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module pmem_arbiter
    import pmem_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [XLEN-1:0] ifu_addr,
    output logic            ifu_resp_valid,
    output logic [XLEN-1:0] ifu_rdata,

    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic            lsu_wen,
    input  logic            lsu_signed,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic [XLEN-1:0] lsu_rmask,
    output logic            lsu_resp_valid,
    output logic [XLEN-1:0] lsu_rdata,

    output logic            pmem_mem_en,
    output logic            pmem_w_en,
    output logic            pmem_signed_en,
    output logic [XLEN-1:0] pmem_addr,
    output logic [XLEN-1:0] pmem_w_data,
    output logic [XLEN-1:0] pmem_r_mask,
    input  logic [XLEN-1:0] pmem_r_data,

    output logic            busy
);

    state_e          state_q, state_d;
    req_id_e         owner_q;
    req_id_e         last_grant;

    logic            wen_q;
    logic            signed_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rmask_q;
    logic [XLEN-1:0] rdata_q;

    logic [1:0]      grant;
    logic            in_idle, in_access, in_resp;
    logic            ifu_hs, lsu_hs, any_hs;

    assign in_idle   = (state_q == IDLE);
    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

`ifdef PMEM_ARB_RR_EN
    req_id_e ptr_q;

    // The pointer only moves on a real handshake, so a valid withdrawn before
    // being accepted leaves the arbitration order untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= IFU;
        end else if (any_hs) begin
            ptr_q <= lsu_hs ? LSU : IFU;
        end
    end

    assign last_grant = ptr_q;
`else
    // Pretending the IFU was always granted last makes every conflict go to
    // the LSU without any state.
    assign last_grant = IFU;
`endif

    pmem_grant u_grant (
        .ifu_valid_i (ifu_req_valid),
        .lsu_valid_i (lsu_req_valid),
        .last_i      (last_grant),
        .grant_o     (grant)
    );

    assign ifu_req_ready = in_idle && grant[0];
    assign lsu_req_ready = in_idle && grant[1];

    assign ifu_hs = ifu_req_valid && ifu_req_ready;
    assign lsu_hs = lsu_req_valid && lsu_req_ready;
    assign any_hs = ifu_hs || lsu_hs;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_hs) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= IFU;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (any_hs) begin
                owner_q <= lsu_hs ? LSU : IFU;
            end
            // Stores acknowledge with zero data, so nothing from the Pmem
            // read port is captured for them.
            if (in_access) begin
                rdata_q <= wen_q ? '0 : pmem_r_data;
            end
        end
    end

    // Request fields only matter while the FSM is in ACCESS, so they need no reset.
    always_ff @(posedge clock) begin
        if (lsu_hs) begin
            addr_q   <= lsu_addr;
            wdata_q  <= lsu_wdata;
            rmask_q  <= lsu_rmask;
            wen_q    <= lsu_wen;
            signed_q <= lsu_signed;
        end else if (ifu_hs) begin
            addr_q   <= ifu_addr;
            wdata_q  <= '0;
            rmask_q  <= '1;
            wen_q    <= 1'b0;
            signed_q <= 1'b0;
        end
    end

    assign pmem_mem_en    = in_access;
    assign pmem_w_en      = in_access && wen_q;
    assign pmem_signed_en = in_access && signed_q;
    assign pmem_addr      = in_access ? addr_q  : '0;
    assign pmem_w_data    = in_access ? wdata_q : '0;
    assign pmem_r_mask    = in_access ? rmask_q : '0;

    assign ifu_resp_valid = in_resp && (owner_q == IFU);
    assign lsu_resp_valid = in_resp && (owner_q == LSU);
    assign ifu_rdata      = ifu_resp_valid ? rdata_q : '0;
    assign lsu_rdata      = lsu_resp_valid ? rdata_q : '0;

    assign busy = !in_idle;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter with a response scoreboard.
// Build with or without +define+PMEM_ARB_RR_EN; expectations follow the mode.
module tb_pmem_arbiter;

    localparam int XLEN = 64;
    localparam logic [63:0] A_IFU  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] A_ST   = 64'h0000_0000_8000_0100;
    localparam logic [63:0] A_LD   = 64'h0000_0000_8000_0200;
    localparam logic [63:0] A_PULSE = 64'h0000_0000_8000_0300;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            ifu_req_valid = 1'b0, ifu_req_ready;
    logic [XLEN-1:0] ifu_addr = '0;
    logic            ifu_resp_valid;
    logic [XLEN-1:0] ifu_rdata;
    logic            lsu_req_valid = 1'b0, lsu_req_ready;
    logic            lsu_wen = 1'b0, lsu_signed = 1'b0;
    logic [XLEN-1:0] lsu_addr = '0, lsu_wdata = '0, lsu_rmask = '0;
    logic            lsu_resp_valid;
    logic [XLEN-1:0] lsu_rdata;
    logic            pmem_mem_en, pmem_w_en, pmem_signed_en;
    logic [XLEN-1:0] pmem_addr, pmem_w_data, pmem_r_mask, pmem_r_data;
    logic            busy;
    logic [XLEN-1:0] mem_word;

    pmem_arbiter #(.XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_signed(lsu_signed), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rmask(lsu_rmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .pmem_mem_en(pmem_mem_en), .pmem_w_en(pmem_w_en), .pmem_signed_en(pmem_signed_en),
        .pmem_addr(pmem_addr), .pmem_w_data(pmem_w_data), .pmem_r_mask(pmem_r_mask),
        .pmem_r_data(pmem_r_data), .busy(busy)
    );

    always #5 clock = ~clock;

    // Memory content table; the read port applies the mask and answers whenever enabled.
    always_comb begin
        mem_word = 64'hBAD0_BAD0_BAD0_BAD0;
        case (pmem_addr)
            A_IFU:   mem_word = 64'h0000_0000_0000_0013;
            A_LD:    mem_word = 64'h1122_3344_5566_7788;
            default: mem_word = 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
        pmem_r_data = pmem_mem_en ? (mem_word & pmem_r_mask) : 64'h0;
    end

    typedef struct {
        bit          lsu;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   hs_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input bit lsu, input logic [63:0] data);
        exp_t e;
        e.lsu  = lsu;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: records handshake cycles and checks every response against the queue.
    always @(negedge clock) begin
        if (!reset) begin
            exp_t e;
            int   h;
            if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready))
                hs_q.push_back(cyc);
            chk("ifu_rdata_idle_zero", ifu_resp_valid ? 64'h0 : ifu_rdata, 64'h0);
            chk("lsu_rdata_idle_zero", lsu_resp_valid ? 64'h0 : lsu_rdata, 64'h0);
            if (ifu_resp_valid || lsu_resp_valid) begin
                if (ifu_resp_valid && lsu_resp_valid) begin
                    chk("both_resp_valid", 64'h1, 64'h0);
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {63'h0, lsu_resp_valid}, 64'hFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_owner_lsu", {63'h0, lsu_resp_valid}, {63'h0, e.lsu});
                    chk("resp_data", lsu_resp_valid ? lsu_rdata : ifu_rdata, e.data);
                    if (hs_q.size() != 0) begin
                        h = hs_q.pop_front();
                        chk("resp_latency", 64'(cyc - h), 64'd2);
                    end else begin
                        chk("resp_without_handshake", 64'h1, 64'h0);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Presents one request, waits (bounded) for its handshake and returns #1 into ACCESS.
    task automatic issue(input bit lsu, input bit wen, input bit sgn,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rmask);
        bit ok;
        @(posedge clock); #1;
        if (lsu) begin
            lsu_req_valid = 1'b1; lsu_wen = wen; lsu_signed = sgn;
            lsu_addr = addr; lsu_wdata = wdata; lsu_rmask = rmask;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = addr;
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (lsu ? lsu_req_ready : ifu_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("handshake_timeout", 64'h0, 64'h1);
        @(posedge clock); #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_wen = 1'b0;
        lsu_signed = 1'b0;
    endtask

    bit exp_first_lsu;
    bit rr_mode;
    int n_hs;
    int guard;

    initial begin
`ifdef PMEM_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        do_reset();
        // reset state
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_mem_en", {63'h0, pmem_mem_en}, 64'h0);
        chk("rst_resp", {62'h0, ifu_resp_valid, lsu_resp_valid}, 64'h0);
        chk("rst_ready_no_valid", {62'h0, ifu_req_ready, lsu_req_ready}, 64'h0);
        chk("rst_pmem_addr", pmem_addr, 64'h0);

        // IFU fetch
        push_exp(1'b0, 64'h13);
        issue(1'b0, 1'b0, 1'b0, A_IFU, 64'h0, 64'h0);
        chk("ifu_acc_mem_en", {63'h0, pmem_mem_en}, 64'h1);
        chk("ifu_acc_w_en", {63'h0, pmem_w_en}, 64'h0);
        chk("ifu_acc_addr", pmem_addr, A_IFU);
        chk("ifu_acc_rmask", pmem_r_mask, ONES);
        chk("ifu_acc_wdata", pmem_w_data, 64'h0);
        chk("ifu_acc_busy_readys", {61'h0, busy, ifu_req_ready, lsu_req_ready}, 64'h4);
        @(posedge clock); #1;
        chk("ifu_resp_mem_en_low", {63'h0, pmem_mem_en}, 64'h0);

        // LSU store
        push_exp(1'b1, 64'h0);
        issue(1'b1, 1'b1, 1'b0, A_ST, 64'hDEAD_BEEF, ONES);
        chk("st_acc_w_en", {63'h0, pmem_w_en}, 64'h1);
        chk("st_acc_addr", pmem_addr, A_ST);
        chk("st_acc_wdata", pmem_w_data, 64'hDEAD_BEEF);
        @(posedge clock); #1;
        chk("st_resp_w_en_low", {63'h0, pmem_w_en}, 64'h0);
        chk("st_resp_wdata_zero", pmem_w_data, 64'h0);

        // LSU signed, masked load
        push_exp(1'b1, 64'h7788);
        issue(1'b1, 1'b0, 1'b1, A_LD, 64'h0, 64'hFFFF);
        chk("ld_acc_signed", {63'h0, pmem_signed_en}, 64'h1);
        chk("ld_acc_rmask", pmem_r_mask, 64'hFFFF);
        chk("ld_acc_w_en", {63'h0, pmem_w_en}, 64'h0);
        @(posedge clock); #1;
        chk("ld_resp_signed_low", {63'h0, pmem_signed_en}, 64'h0);

        // Both valid continuously for six transactions, from a fresh reset
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (rr_mode ? (i % 2 == 0) : 1'b1) push_exp(1'b1, 64'h1122_3344_5566_7788);
            else                               push_exp(1'b0, 64'h13);
        end
        @(posedge clock); #1;
        ifu_req_valid = 1'b1; ifu_addr = A_IFU;
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_signed = 1'b0;
        lsu_addr = A_LD; lsu_rmask = ONES;
        n_hs = 0;
        guard = 0;
        while (n_hs < 6 && guard < 60) begin
            @(negedge clock);
            guard++;
            if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) n_hs++;
        end
        if (n_hs < 6) chk("conflict_timeout", 64'(n_hs), 64'd6);
        @(posedge clock); #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // Reset during ACCESS aborts the transaction
        issue(1'b0, 1'b0, 1'b0, A_IFU, 64'h0, 64'h0);
        chk("abort_in_access", {63'h0, pmem_mem_en}, 64'h1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        hs_q.delete();
        chk("abort_busy_low", {63'h0, busy}, 64'h0);
        chk("abort_mem_en_low", {63'h0, pmem_mem_en}, 64'h0);
        repeat (3) @(negedge clock);
        push_exp(1'b0, 64'h13);
        issue(1'b0, 1'b0, 1'b0, A_IFU, 64'h0, 64'h0);
        chk("after_abort_access", {63'h0, pmem_mem_en}, 64'h1);
        @(posedge clock); #1;

        // IFU valid pulsed while busy: ignored, pointer left at LSU
        push_exp(1'b1, 64'h1122_3344_5566_7788);
        issue(1'b1, 1'b0, 1'b0, A_LD, 64'h0, ONES);
        ifu_req_valid = 1'b1; ifu_addr = A_PULSE;
        @(negedge clock);
        chk("pulse_ifu_ready_low", {63'h0, ifu_req_ready}, 64'h0);
        @(posedge clock); #1;
        ifu_req_valid = 1'b0;
        chk("pulse_resp_mem_en_low", {63'h0, pmem_mem_en}, 64'h0);
        @(posedge clock); #1;
        chk("pulse_idle_busy_low", {63'h0, busy}, 64'h0);
        @(negedge clock);
        chk("pulse_no_extra_access", {63'h0, pmem_mem_en}, 64'h0);
        exp_first_lsu = !rr_mode;
        if (exp_first_lsu) push_exp(1'b1, 64'h1122_3344_5566_7788);
        else               push_exp(1'b0, 64'h13);
        @(posedge clock); #1;
        ifu_req_valid = 1'b1; ifu_addr = A_IFU;
        lsu_req_valid = 1'b1; lsu_addr = A_LD; lsu_rmask = ONES;
        @(negedge clock);
        chk("ptr_after_pulse_grant", {62'h0, ifu_req_ready, lsu_req_ready},
            exp_first_lsu ? 64'h1 : 64'h2);
        @(posedge clock); #1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clock);
            guard++;
        end
        @(negedge clock);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
